ds_operand_ctrl: RTL and testbench

DS_OPERAND_CTRL -- requirements
Module: ds_operand_ctrl

---
 rtl/ds_operand_ctrl.sv | 158 +++++++++++++++
 tb/tb_ds_operand_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ds_operand_ctrl.sv
// Decode-stage operand controller: holds one instruction, resolves its source
// operands from the forwarding network or the regfile, and interlocks on pending data.
module ds_operand_ctrl #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NFWD = 3,
  parameter int PW   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fs_to_ds_valid,
  input  logic [PW-1:0]        fs_payload,
  input  logic [AW-1:0]        fs_rs,
  input  logic [AW-1:0]        fs_rt,
  input  logic                 fs_rs_used,
  input  logic                 fs_rt_used,
  output logic                 ds_allowin,
  input  logic                 es_allowin,
  output logic                 ds_to_es_valid,
  output logic [PW-1:0]        ds_payload,
  output logic [DW-1:0]        ds_rs_val,
  output logic [DW-1:0]        ds_rt_val,
  output logic [AW-1:0]        rf_raddr1,
  output logic [AW-1:0]        rf_raddr2,
  input  logic [DW-1:0]        rf_rdata1,
  input  logic [DW-1:0]        rf_rdata2,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD-1:0]      fwd_we,
  input  logic [NFWD-1:0]      fwd_data_ok,
  input  logic [NFWD*AW-1:0]   fwd_addr,
  input  logic [NFWD*DW-1:0]   fwd_data,
  input  logic                 flush,
  input  logic                 stat_clr,
  output logic [15:0]          stall_cnt
);

  logic              r_ds_valid;
  logic [PW-1:0]     r_payload;
  logic [AW-1:0]     r_rs;
  logic [AW-1:0]     r_rt;
  logic              r_rs_used;
  logic              r_rt_used;
  logic [15:0]       r_stall_cnt;

  logic [DW:0]       w_rs_res;
  logic [DW:0]       w_rt_res;
  logic              w_hazard_rs;
  logic              w_hazard_rt;
  logic              w_ready_go;
  logic              w_allowin;
  logic              w_load;

  // Returns {hazard, value}. Scanning oldest-to-youngest lets the youngest match
  // overwrite, so a ready older source can never hide a pending younger one.
  function automatic logic [DW:0] resolve(
    input logic [AW-1:0]      x,
    input logic               used,
    input logic [DW-1:0]      rf_val,
    input logic [NFWD-1:0]    f_valid,
    input logic [NFWD-1:0]    f_we,
    input logic [NFWD-1:0]    f_ok,
    input logic [NFWD*AW-1:0] f_addr,
    input logic [NFWD*DW-1:0] f_data
  );
    logic [DW-1:0] val;
    logic          hit;
    logic          ok;
    val = rf_val;
    hit = 1'b0;
    ok  = 1'b1;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (f_valid[i] && f_we[i] && (f_addr[i*AW +: AW] == x) && (x != '0) && used) begin
        hit = 1'b1;
        val = f_data[i*DW +: DW];
        ok  = f_ok[i];
      end else begin
        hit = hit;
      end
    end
    if (x == '0) begin
      val = '0;
    end else begin
      val = val;
    end
    return {hit && !ok, val};
  endfunction

  assign rf_raddr1 = r_rs;
  assign rf_raddr2 = r_rt;

  // Operand resolution and handshake
  always_comb begin
    w_rs_res    = resolve(r_rs, r_rs_used, rf_rdata1, fwd_valid, fwd_we, fwd_data_ok, fwd_addr, fwd_data);
    w_rt_res    = resolve(r_rt, r_rt_used, rf_rdata2, fwd_valid, fwd_we, fwd_data_ok, fwd_addr, fwd_data);
    w_hazard_rs = w_rs_res[DW];
    w_hazard_rt = w_rt_res[DW];
    w_ready_go  = !(w_hazard_rs || w_hazard_rt);
    w_allowin   = !r_ds_valid || (w_ready_go && es_allowin);
    w_load      = fs_to_ds_valid && w_allowin && !flush;
  end

  assign ds_rs_val      = w_rs_res[DW-1:0];
  assign ds_rt_val      = w_rt_res[DW-1:0];
  assign ds_allowin     = w_allowin;
  assign ds_to_es_valid = r_ds_valid && w_ready_go && !flush;
  assign ds_payload     = r_payload;
  assign stall_cnt      = r_stall_cnt;

  // Stage valid bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ds_valid <= 1'b0;
    end else if (flush) begin
      r_ds_valid <= 1'b0;
    end else if (w_allowin) begin
      r_ds_valid <= fs_to_ds_valid;
    end else begin
      r_ds_valid <= r_ds_valid;
    end
  end

  // Instruction fields, held stable while stalled or back-pressured
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_payload <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rs_used <= 1'b0;
      r_rt_used <= 1'b0;
    end else if (w_load) begin
      r_payload <= fs_payload;
      r_rs      <= fs_rs;
      r_rt      <= fs_rt;
      r_rs_used <= fs_rs_used;
      r_rt_used <= fs_rt_used;
    end else begin
      r_payload <= r_payload;
      r_rs      <= r_rs;
      r_rt      <= r_rt;
      r_rs_used <= r_rs_used;
      r_rt_used <= r_rt_used;
    end
  end

  // Saturating interlock counter; clear wins over increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= 16'h0000;
    end else if (stat_clr) begin
      r_stall_cnt <= 16'h0000;
    end else if (r_ds_valid && !w_ready_go && !flush && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

endmodule

// File: tb/tb_ds_operand_ctrl.sv
// Directed bench for ds_operand_ctrl: regfile model plus hand-computed expectations.
module tb_ds_operand_ctrl;

  logic        clk;
  logic        reset;
  logic        fs_to_ds_valid;
  logic [63:0] fs_payload;
  logic [4:0]  fs_rs;
  logic [4:0]  fs_rt;
  logic        fs_rs_used;
  logic        fs_rt_used;
  logic        ds_allowin;
  logic        es_allowin;
  logic        ds_to_es_valid;
  logic [63:0] ds_payload;
  logic [31:0] ds_rs_val;
  logic [31:0] ds_rt_val;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic [2:0]  fwd_valid;
  logic [2:0]  fwd_we;
  logic [2:0]  fwd_data_ok;
  logic [14:0] fwd_addr;
  logic [95:0] fwd_data;
  logic        flush;
  logic        stat_clr;
  logic [15:0] stall_cnt;

  logic [31:0] rf_mem [32];
  int checks;
  int errors;

  assign rf_rdata1 = rf_mem[rf_raddr1];
  assign rf_rdata2 = rf_mem[rf_raddr2];

  ds_operand_ctrl #(.DW(32), .AW(5), .NFWD(3), .PW(64)) dut (
    .clk(clk), .reset(reset), .fs_to_ds_valid(fs_to_ds_valid), .fs_payload(fs_payload),
    .fs_rs(fs_rs), .fs_rt(fs_rt), .fs_rs_used(fs_rs_used), .fs_rt_used(fs_rt_used),
    .ds_allowin(ds_allowin), .es_allowin(es_allowin), .ds_to_es_valid(ds_to_es_valid),
    .ds_payload(ds_payload), .ds_rs_val(ds_rs_val), .ds_rt_val(ds_rt_val),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_valid(fwd_valid), .fwd_we(fwd_we), .fwd_data_ok(fwd_data_ok), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .flush(flush), .stat_clr(stat_clr), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fwd(input int i, input logic v, input logic we, input logic [4:0] a,
                         input logic [31:0] d, input logic ok);
    fwd_valid[i]        = v;
    fwd_we[i]           = we;
    fwd_addr[i*5 +: 5]  = a;
    fwd_data[i*32 +: 32] = d;
    fwd_data_ok[i]      = ok;
  endtask

  task automatic clear_fwd();
    fwd_valid = 3'b000; fwd_we = 3'b000; fwd_data_ok = 3'b000;
    fwd_addr = 15'd0; fwd_data = 96'd0;
  endtask

  // Offers one instruction for one cycle; returns 1 ns after the capturing edge.
  task automatic issue(input logic [63:0] p, input logic [4:0] rs, input logic [4:0] rt,
                       input logic rsu, input logic rtu);
    fs_to_ds_valid = 1'b1; fs_payload = p; fs_rs = rs; fs_rt = rt;
    fs_rs_used = rsu; fs_rt_used = rtu;
    tick();
    fs_to_ds_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    checks++; if (ds_to_es_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", ds_to_es_valid); end
    checks++; if (ds_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin got %0b exp 1", ds_allowin); end
    checks++; if (stall_cnt !== 16'h0000) begin errors++; $display("FAIL reset_cnt got %h exp 0000", stall_cnt); end
    checks++; if (ds_payload !== 64'd0) begin errors++; $display("FAIL reset_payload got %h exp 0", ds_payload); end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_rf_path();
    issue(64'h1111_0000_0000_0001, 5'd5, 5'd7, 1'b1, 1'b0);
    checks++; if (ds_rs_val !== 32'h11) begin errors++; $display("FAIL rf_rs_val got %h exp 00000011", ds_rs_val); end
    checks++; if (ds_to_es_valid !== 1'b1) begin errors++; $display("FAIL rf_valid got %0b exp 1", ds_to_es_valid); end
    checks++; if (rf_raddr1 !== 5'd5) begin errors++; $display("FAIL rf_raddr1 got %0d exp 5", rf_raddr1); end
    checks++; if (ds_rt_val !== 32'h77) begin errors++; $display("FAIL rf_unused_rt got %h exp 00000077", ds_rt_val); end
    checks++; if (ds_payload !== 64'h1111_0000_0000_0001) begin errors++; $display("FAIL rf_payload got %h", ds_payload); end
    tick();
  endtask

  task automatic test_fwd_priority();
    set_fwd(0, 1'b1, 1'b1, 5'd5, 32'hAA, 1'b1);
    set_fwd(2, 1'b1, 1'b1, 5'd5, 32'hBB, 1'b1);
    issue(64'h2222, 5'd5, 5'd0, 1'b1, 1'b0);
    checks++; if (ds_rs_val !== 32'hAA) begin errors++; $display("FAIL fwd_young got %h exp 000000aa", ds_rs_val); end
    fwd_we[0] = 1'b0;
    #1;
    checks++; if (ds_rs_val !== 32'hBB) begin errors++; $display("FAIL fwd_we_gate got %h exp 000000bb", ds_rs_val); end
    fwd_we[0] = 1'b1;
    set_fwd(1, 1'b1, 1'b1, 5'd5, 32'hCC, 1'b1);
    fwd_valid[0] = 1'b0;
    #1;
    checks++; if (ds_rs_val !== 32'hCC) begin errors++; $display("FAIL fwd_mid got %h exp 000000cc", ds_rs_val); end
    fwd_valid[0] = 1'b1; fwd_data_ok[0] = 1'b0;
    #1;
    checks++; if (ds_to_es_valid !== 1'b0 || ds_allowin !== 1'b0) begin
      errors++; $display("FAIL fwd_young_pending got valid=%0b allowin=%0b exp 0 0", ds_to_es_valid, ds_allowin); end
    clear_fwd();
    #1;
    checks++; if (ds_rs_val !== 32'h11) begin errors++; $display("FAIL fwd_none got %h exp 00000011", ds_rs_val); end
    tick();
  endtask

  task automatic test_stall();
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    set_fwd(0, 1'b1, 1'b1, 5'd7, 32'h0, 1'b0);
    issue(64'h3333, 5'd0, 5'd7, 1'b0, 1'b1);
    for (int c = 0; c < 2; c++) begin
      checks++; if (ds_allowin !== 1'b0 || ds_to_es_valid !== 1'b0) begin
        errors++; $display("FAIL stall_hold c=%0d got allowin=%0b valid=%0b exp 0 0", c, ds_allowin, ds_to_es_valid); end
      checks++; if (stall_cnt !== c[15:0]) begin errors++; $display("FAIL stall_cnt_run c=%0d got %0d", c, stall_cnt); end
      tick();
    end
    set_fwd(0, 1'b1, 1'b1, 5'd7, 32'h33, 1'b1);
    #1;
    checks++; if (ds_rt_val !== 32'h33 || ds_to_es_valid !== 1'b1) begin
      errors++; $display("FAIL stall_release got val=%h valid=%0b exp 00000033 1", ds_rt_val, ds_to_es_valid); end
    checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL stall_cnt got %0d exp 2", stall_cnt); end
    tick();
    clear_fwd();
    checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL stall_cnt_after got %0d exp 2", stall_cnt); end
  endtask

  task automatic test_r0_unused();
    set_fwd(0, 1'b1, 1'b1, 5'd0, 32'h55, 1'b0);
    issue(64'h4444, 5'd0, 5'd0, 1'b1, 1'b1);
    checks++; if (ds_rs_val !== 32'h0 || ds_to_es_valid !== 1'b1) begin
      errors++; $display("FAIL r0 got val=%h valid=%0b exp 00000000 1", ds_rs_val, ds_to_es_valid); end
    tick();
    set_fwd(0, 1'b1, 1'b1, 5'd9, 32'h99, 1'b0);
    issue(64'h5555, 5'd9, 5'd0, 1'b0, 1'b0);
    checks++; if (ds_to_es_valid !== 1'b1 || ds_rs_val !== 32'h1009) begin
      errors++; $display("FAIL unused got valid=%0b val=%h exp 1 00001009", ds_to_es_valid, ds_rs_val); end
    tick();
    clear_fwd();
  endtask

  task automatic test_back_to_back();
    fs_to_ds_valid = 1'b1; fs_payload = 64'hB1; fs_rs = 5'd5; fs_rs_used = 1'b1; fs_rt = 5'd0; fs_rt_used = 1'b0;
    tick();
    fs_payload = 64'hB2; fs_rs = 5'd7;
    checks++; if (ds_payload !== 64'hB1 || ds_rs_val !== 32'h11 || ds_to_es_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_first got p=%h v=%h valid=%0b", ds_payload, ds_rs_val, ds_to_es_valid); end
    tick();
    fs_to_ds_valid = 1'b0;
    checks++; if (ds_payload !== 64'hB2 || ds_rs_val !== 32'h77 || ds_to_es_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_second got p=%h v=%h valid=%0b", ds_payload, ds_rs_val, ds_to_es_valid); end
    tick();
    checks++; if (ds_to_es_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b exp 0", ds_to_es_valid); end
  endtask

  task automatic test_backpressure_flush();
    es_allowin = 1'b0;
    issue(64'hA0A0, 5'd5, 5'd0, 1'b1, 1'b0);
    fs_to_ds_valid = 1'b1; fs_payload = 64'hB0B0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (ds_payload !== 64'hA0A0 || ds_allowin !== 1'b0 || ds_to_es_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold c=%0d got p=%h allowin=%0b valid=%0b", c, ds_payload, ds_allowin, ds_to_es_valid); end
      tick();
    end
    flush = 1'b1;
    #1;
    checks++; if (ds_to_es_valid !== 1'b0) begin errors++; $display("FAIL flush_comb got %0b exp 0", ds_to_es_valid); end
    tick();
    flush = 1'b0; fs_to_ds_valid = 1'b0; es_allowin = 1'b1;
    #1;
    checks++; if (ds_to_es_valid !== 1'b0 || ds_allowin !== 1'b1 || ds_payload !== 64'hA0A0) begin
      errors++; $display("FAIL flush_drop got valid=%0b allowin=%0b p=%h", ds_to_es_valid, ds_allowin, ds_payload); end
    tick();
  endtask

  task automatic test_reset_midstall();
    set_fwd(0, 1'b1, 1'b1, 5'd7, 32'h0, 1'b0);
    issue(64'hC0C0, 5'd0, 5'd7, 1'b0, 1'b1);
    checks++; if (ds_allowin !== 1'b0) begin errors++; $display("FAIL midstall_pre got %0b exp 0", ds_allowin); end
    #2 reset = 1'b0;
    #1;
    checks++; if (ds_allowin !== 1'b1 || ds_to_es_valid !== 1'b0 || stall_cnt !== 16'd0 || ds_payload !== 64'd0) begin
      errors++; $display("FAIL midstall_reset got allowin=%0b valid=%0b cnt=%0d p=%h", ds_allowin, ds_to_es_valid, stall_cnt, ds_payload); end
    #2 reset = 1'b1;
    tick();
    checks++; if (ds_allowin !== 1'b1 || ds_to_es_valid !== 1'b0) begin
      errors++; $display("FAIL midstall_release got allowin=%0b valid=%0b exp 1 0", ds_allowin, ds_to_es_valid); end
    clear_fwd();
  endtask

  task automatic test_saturate();
    set_fwd(0, 1'b1, 1'b1, 5'd7, 32'h0, 1'b0);
    issue(64'hD0D0, 5'd0, 5'd7, 1'b0, 1'b1);
    repeat (65540) tick();
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h exp ffff", stall_cnt); end
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    checks++; if (stall_cnt !== 16'h0000) begin errors++; $display("FAIL sat_clr got %h exp 0000", stall_cnt); end
    tick();
    checks++; if (stall_cnt !== 16'h0001) begin errors++; $display("FAIL sat_restart got %h exp 0001", stall_cnt); end
    set_fwd(0, 1'b1, 1'b1, 5'd7, 32'h5A, 1'b1);
    #1;
    checks++; if (ds_to_es_valid !== 1'b1 || ds_rt_val !== 32'h5A) begin
      errors++; $display("FAIL sat_release got valid=%0b val=%h", ds_to_es_valid, ds_rt_val); end
    tick();
    clear_fwd();
  endtask

  initial begin
    checks = 0; errors = 0;
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h1000 + i;
    rf_mem[0] = 32'h0; rf_mem[5] = 32'h11; rf_mem[7] = 32'h77;
    fs_to_ds_valid = 1'b0; fs_payload = 64'd0; fs_rs = 5'd0; fs_rt = 5'd0;
    fs_rs_used = 1'b0; fs_rt_used = 1'b0; es_allowin = 1'b1;
    flush = 1'b0; stat_clr = 1'b0;
    clear_fwd();
    test_reset();
    test_rf_path();
    test_fwd_priority();
    test_stall();
    test_r0_unused();
    test_back_to_back();
    test_backpressure_flush();
    test_reset_midstall();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
